// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared definitions for the 8-requester round-robin mux scheduler.
//   N_REQ          number of requesters
//   SEL_W          width of the mux select / owner index
//   sched_state_t  scheduler FSM states
//   rot_first()    index of the first set request, scanning circularly upward from ptr
package mux8_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  // Returns ptr when no request is set; callers qualify the result with |req.
  function automatic logic [SEL_W-1:0] rot_first(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    idx = ptr;
    // Walk from the farthest candidate back toward ptr so the nearest one wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_rr_pick.sv
// Combinational circular priority search.
//   req  [7:0] in   request vector
//   ptr  [2:0] in   highest-priority index
//   idx  [2:0] out  winning requester index (valid when any=1)
//   any        out  at least one request is set
module rr_pick
  import mux8_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Rotate the request vector so that bit 0 corresponds to requester ptr.
  logic [N_REQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[SEL_W'(ptr + SEL_W'(gi))];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  assign idx = ptr + rot_first(rot, '0);
  assign any = |req;

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.
// An owner keeps the mux while its req stays high, for at most MAX_HOLD cycles;
// a single dead cycle separates successive owners.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   1 = new grants allowed (a running owner is unaffected)
//   req[7:0] in   request vector
//   grant    out  one-hot owner, zero when idle
//   busy     out  a grant is active
//   s0/s1/s2 out  mux select (owner index), holds its last value when idle
//   expired  out  one-cycle pulse after a MAX_HOLD release
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             expired
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  sched_state_t     state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] owner_reg, owner_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic             expired_reg, expired_next;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             hold_hit;
  logic             release_now;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign hold_hit    = (cnt_reg == HOLD_LIM);
  assign release_now = !req[owner_reg] || hold_hit;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    owner_next   = owner_reg;
    cnt_next     = cnt_reg;
    grant_next   = grant_reg;
    expired_next = 1'b0;

    case (state_reg)
      // GAP arbitrates exactly like IDLE: its single cycle with grant=0 is the
      // dead cycle, and the new owner appears on the following edge.
      IDLE, GAP: begin
        if (en && pick_any) begin
          state_next = GRANT;
          owner_next = pick_idx;
          grant_next = N_REQ'(1) << pick_idx;
          cnt_next   = 8'd1;
        end else begin
          state_next = IDLE;
        end
      end

      GRANT: begin
        if (release_now) begin
          state_next   = GAP;
          grant_next   = '0;
          // Previous owner drops to lowest priority; 3-bit add wraps 7 -> 0.
          ptr_next     = owner_reg + 1'b1;
          expired_next = hold_hit;
          cnt_next     = 8'd0;
        end else if (!hold_hit) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      owner_reg   <= '0;
      cnt_reg     <= '0;
      grant_reg   <= '0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      owner_reg   <= owner_next;
      cnt_reg     <= cnt_next;
      grant_reg   <= grant_next;
      expired_reg <= expired_next;
    end
  end

  // owner_reg only changes on a new grant, so it doubles as the held mux select.
  assign grant   = grant_reg;
  assign busy    = |grant_reg;
  assign s0      = owner_reg[0];
  assign s1      = owner_reg[1];
  assign s2      = owner_reg[2];
  assign expired = expired_reg;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Randomized bench for mux8_rr_scheduler: two instances (MAX_HOLD=16 and 1)
// share the same stimulus and are compared every cycle against a behavioural model.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] grant16, grant1;
  logic       busy16, busy1;
  logic       s0_16, s1_16, s2_16, s0_1, s1_1, s2_1;
  logic       exp16, exp1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(grant16), .busy(busy16), .s0(s0_16), .s1(s1_16), .s2(s2_16), .expired(exp16)
  );

  mux8_rr_scheduler #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(grant1), .busy(busy1), .s0(s0_1), .s1(s1_1), .s2(s2_1), .expired(exp1)
  );

  // Behavioural model: who owns the mux, for how long, and who is next in line.
  typedef struct {
    bit own;
    int owner;
    int cnt;
    int ptr;
    int sel;
    bit exp;
  } mdl_t;

  mdl_t m16, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.own = 0; m.owner = 0; m.cnt = 0; m.ptr = 0; m.sel = 0; m.exp = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int hold, input bit e,
                                    input logic [7:0] r);
    mdl_t n;
    bit   found;
    int   cand;
    n = m;
    found = 0;
    if (m.own) begin
      if (r[m.owner] == 1'b0 || m.cnt >= hold) begin
        n.own = 0;
        n.exp = (m.cnt >= hold);
        n.ptr = (m.owner + 1) % 8;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end else begin
      n.exp = 0;
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          cand = (m.ptr + k) % 8;
          if (!found && r[cand]) begin
            found   = 1;
            n.own   = 1;
            n.owner = cand;
            n.cnt   = 1;
            n.sel   = cand;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("grant16",   {24'd0, grant16}, m16.own ? (32'd1 << m16.owner) : 32'd0);
    check_eq("busy16",    {31'd0, busy16}, {31'd0, m16.own});
    check_eq("sel16",     {29'd0, s2_16, s1_16, s0_16}, m16.sel);
    check_eq("expired16", {31'd0, exp16}, {31'd0, m16.exp});
    check_eq("grant1",    {24'd0, grant1}, m1.own ? (32'd1 << m1.owner) : 32'd0);
    check_eq("busy1",     {31'd0, busy1}, {31'd0, m1.own});
    check_eq("sel1",      {29'd0, s2_1, s1_1, s0_1}, m1.sel);
    check_eq("expired1",  {31'd0, exp1}, {31'd0, m1.exp});
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare at negedge.
  task automatic step(input logic e, input logic [7:0] r);
    bit was_own;
    en  = e;
    req = r;
    @(posedge clk);
    was_own = m16.own;
    m16 = mdl_next(m16, 16, e, r);
    m1  = mdl_next(m1, 1, e, r);
    cyc++;
    @(negedge clk);
    if (m16.own && !was_own)
      $display("cyc=%0d grant16 owner=%0d req=%02h en=%0d", cyc, m16.owner, r, e);
    check_all();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_grant16", {24'd0, grant16}, 32'd0);
    check_eq("rst_busy16",  {31'd0, busy16}, 32'd0);
    check_eq("rst_sel16",   {29'd0, s2_16, s1_16, s0_16}, 32'd0);
    check_eq("rst_exp16",   {31'd0, exp16}, 32'd0);
    check_eq("rst_grant1",  {24'd0, grant1}, 32'd0);
    check_eq("rst_sel1",    {29'd0, s2_1, s1_1, s0_1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m16 = mdl_reset();
    m1  = mdl_reset();
    $display("cyc=%0d async reset applied", cyc);
  endtask

  initial begin
    logic [7:0] rr;
    logic [7:0] mask;
    int         dens;
    bit         ee;

    m16 = mdl_reset();
    m1  = mdl_reset();

    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Two requesters held at MAX_HOLD=16: owner 0 expires, one gap, then owner 7.
    step(1'b1, 8'h81);
    check_eq("d2_first_grant", {24'd0, grant16}, 32'h01);
    for (int i = 0; i < 15; i++) step(1'b1, 8'h81);
    check_eq("d2_still_owner0", {24'd0, grant16}, 32'h01);
    step(1'b1, 8'h81);
    check_eq("d2_gap_grant", {24'd0, grant16}, 32'h00);
    check_eq("d2_gap_expired", {31'd0, exp16}, 32'd1);
    step(1'b1, 8'h81);
    check_eq("d2_owner7_grant", {24'd0, grant16}, 32'h80);
    check_eq("d2_owner7_sel", {29'd0, s2_16, s1_16, s0_16}, 32'd7);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h81);

    // en=0 with all requests: no new grant; owners in flight are allowed to finish.
    for (int i = 0; i < 20; i++) step(1'b0, 8'hFF);
    check_eq("d6_en0_idle", {31'd0, busy16}, 32'd0);
    step(1'b1, 8'hFF);
    check_eq("d6_en1_busy", {31'd0, busy16}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF);

    // Reset while an owner is active, then all-request round robin.
    async_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'hFF);

    // Randomized traffic with varying request persistence and occasional en=0.
    rr = 8'h00;
    for (int ph = 0; ph < 12; ph++) begin
      dens = (ph % 3 == 0) ? 40 : ((ph % 3 == 1) ? 8 : 3);
      for (int i = 0; i < 150; i++) begin
        mask = 8'h00;
        for (int b = 0; b < 8; b++)
          if ($urandom_range(dens - 1, 0) == 0) mask[b] = 1'b1;
        rr = rr ^ mask;
        ee = ($urandom_range(9, 0) != 0);
        step(ee, rr);
      end
      if (ph % 4 == 3) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
